// File: rtl/draw_cfg_sched.sv
// rtl/draw_cfg_sched.sv - frame-synchronous shadow/active colour config scheduler
// Writes land in a shadow set; a commit copies it to the active set at the next vblank start.
module draw_cfg_sched #(
  parameter int BLINK_FRAMES = 30,
  parameter int FRAME_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vblnk,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [2:0]             cfg_addr,
  input  logic [11:0]            cfg_data,
  input  logic                   cfg_commit,
  output logic [11:0]            fill_rgb,
  output logic [11:0]            alt_rgb,
  output logic [11:0]            top_rgb,
  output logic [11:0]            bot_rgb,
  output logic [11:0]            left_rgb,
  output logic [11:0]            right_rgb,
  output logic                   edge_en,
  output logic                   blink_phase,
  output logic                   commit_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_FRAMES - 1);
  // Entry 0 is fill; order follows the register address map.
  localparam logic [5:0][11:0] RST_COL = {12'h00f, 12'h0f0, 12'hf00, 12'hff0, 12'h887, 12'h888};
  localparam logic [1:0] RST_CTRL = 2'b01;

  typedef enum logic {S_IDLE, S_PENDING} state_t;

  state_t                 state_q, state_d;
  logic [5:0][11:0]       shadow_q, shadow_d;
  logic [5:0][11:0]       active_q, active_d;
  logic [1:0]             shctrl_q, shctrl_d;
  logic [1:0]             actctrl_q, actctrl_d;
  logic                   done_q, done_d;
  logic                   vblnk_q;
  logic [BCW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                   phase_q, phase_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;
  logic                   vb_start;

  assign vb_start = vblnk & ~vblnk_q;

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    shctrl_d    = shctrl_q;
    active_d    = active_q;
    actctrl_d   = actctrl_q;
    done_d      = 1'b0;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    frame_d     = frame_q + FRAME_CNT_W'(vb_start);
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          if (cfg_addr < 3'd6) shadow_d[cfg_addr] = cfg_data;
          else if (cfg_addr == 3'd6) shctrl_d = cfg_data[1:0];
        end
        // A coinciding vb_start is deliberately not used: the copy waits a frame.
        if (cfg_commit) state_d = S_PENDING;
      end
      S_PENDING: begin
        if (vb_start) begin
          active_d  = shadow_q;
          actctrl_d = shctrl_q;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Blink always follows the ctrl value active before this edge.
    if (!actctrl_q[1]) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (vb_start) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shadow_q    <= RST_COL;
      active_q    <= RST_COL;
      shctrl_q    <= RST_CTRL;
      actctrl_q   <= RST_CTRL;
      done_q      <= 1'b0;
      vblnk_q     <= 1'b1;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      frame_q     <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      shctrl_q    <= shctrl_d;
      actctrl_q   <= actctrl_d;
      done_q      <= done_d;
      vblnk_q     <= vblnk;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      frame_q     <= frame_d;
    end
  end

  assign cfg_ready   = (state_q == S_IDLE);
  assign fill_rgb    = active_q[0];
  assign alt_rgb     = active_q[1];
  assign top_rgb     = active_q[2];
  assign bot_rgb     = active_q[3];
  assign left_rgb    = active_q[4];
  assign right_rgb   = active_q[5];
  assign edge_en     = actctrl_q[0];
  // Gating makes a blink disable take effect on the first cycle of the new config.
  assign blink_phase = phase_q & actctrl_q[1];
  assign commit_done = done_q;
  assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_draw_cfg_sched.sv
// tb/tb_draw_cfg_sched.sv - vector table, directed sequences and randomized model check
// Reference model tracks shadow/active sets as arrays and blink from enabled-frame count.
module tb_draw_cfg_sched;

  localparam int BF = 2;
  localparam int FW = 8;

  logic          clk = 1'b0;
  logic          rst_n, vblnk, cfg_valid, cfg_commit;
  logic [2:0]    cfg_addr;
  logic [11:0]   cfg_data;
  logic          cfg_ready, edge_en, blink_phase, commit_done;
  logic [11:0]   fill_rgb, alt_rgb, top_rgb, bot_rgb, left_rgb, right_rgb;
  logic [FW-1:0] frame_cnt;

  int tests = 0;
  int fails = 0;

  draw_cfg_sched #(.BLINK_FRAMES(BF), .FRAME_CNT_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .vblnk(vblnk), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .fill_rgb(fill_rgb), .alt_rgb(alt_rgb), .top_rgb(top_rgb), .bot_rgb(bot_rgb),
    .left_rgb(left_rgb), .right_rgb(right_rgb), .edge_en(edge_en), .blink_phase(blink_phase),
    .commit_done(commit_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [11:0] m_sh [6];
  logic [11:0] m_act [6];
  logic [1:0]  m_shc, m_actc;
  bit          m_pend, m_done, m_prev;
  int          m_frames, m_enfr;

  task automatic model_reset();
    m_sh   = '{12'h888, 12'h887, 12'hff0, 12'hf00, 12'h0f0, 12'h00f};
    m_act  = m_sh;
    m_shc  = 2'b01;
    m_actc = 2'b01;
    m_pend = 0; m_done = 0; m_prev = 1; m_frames = 0; m_enfr = 0;
  endtask

  task automatic model_edge();
    bit vbs;
    if (!rst_n) begin
      model_reset();
    end else begin
      vbs = vblnk && !m_prev;
      if (m_actc[1]) begin
        if (vbs) m_enfr++;
      end else begin
        m_enfr = 0;
      end
      if (vbs) m_frames++;
      m_done = 0;
      if (m_pend) begin
        if (vbs) begin
          m_act = m_sh; m_actc = m_shc; m_done = 1; m_pend = 0;
        end
      end else begin
        if (cfg_valid) begin
          if (cfg_addr < 6) m_sh[cfg_addr] = cfg_data;
          else if (cfg_addr == 6) m_shc = cfg_data[1:0];
        end
        if (cfg_commit) m_pend = 1;
      end
      m_prev = vblnk;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_fill", 32'(fill_rgb), 32'(m_act[0]));
    chk("m_alt", 32'(alt_rgb), 32'(m_act[1]));
    chk("m_top", 32'(top_rgb), 32'(m_act[2]));
    chk("m_bot", 32'(bot_rgb), 32'(m_act[3]));
    chk("m_left", 32'(left_rgb), 32'(m_act[4]));
    chk("m_right", 32'(right_rgb), 32'(m_act[5]));
    chk("m_edge", 32'(edge_en), 32'(m_actc[0]));
    chk("m_blink", 32'(blink_phase), m_actc[1] ? 32'((m_enfr / BF) % 2) : 32'd0);
    chk("m_ready", 32'(cfg_ready), 32'(!m_pend));
    chk("m_done", 32'(commit_done), 32'(m_done));
    chk("m_frame", 32'(frame_cnt), 32'(m_frames % (1 << FW)));
  endtask

  task automatic idle_in(input logic vb);
    vblnk = vb; cfg_valid = 0; cfg_commit = 0; cfg_addr = 0; cfg_data = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; idle_in(1);
    cyc(); cyc();
    rst_n = 1;
  endtask

  task automatic frame();
    idle_in(0); cyc();
    idle_in(1); cyc();
  endtask

  task automatic write(input logic [2:0] a, input logic [11:0] d, input logic c);
    vblnk = 0; cfg_valid = 1; cfg_addr = a; cfg_data = d; cfg_commit = c;
    cyc();
    idle_in(0);
  endtask

  typedef struct {
    logic        vb, v;
    logic [2:0]  a;
    logic [11:0] d;
    logic        c;
    logic [11:0] fill, alt, top, right;
    logic        rdy, done;
    logic [7:0]  fr;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int ndone;
    logic [2:0] blink_exp;
    tbl[0]  = '{1, 0, 3'd0, 12'h000, 0, 12'h888, 12'h887, 12'hff0, 12'h00f, 1, 0, 8'd0};
    tbl[1]  = '{0, 1, 3'd0, 12'h0f0, 0, 12'h888, 12'h887, 12'hff0, 12'h00f, 1, 0, 8'd0};
    tbl[2]  = '{0, 0, 3'd0, 12'h000, 1, 12'h888, 12'h887, 12'hff0, 12'h00f, 0, 0, 8'd0};
    tbl[3]  = '{0, 1, 3'd1, 12'h111, 0, 12'h888, 12'h887, 12'hff0, 12'h00f, 0, 0, 8'd0};
    tbl[4]  = '{1, 1, 3'd1, 12'h111, 0, 12'h0f0, 12'h887, 12'hff0, 12'h00f, 1, 1, 8'd1};
    tbl[5]  = '{1, 1, 3'd1, 12'h111, 0, 12'h0f0, 12'h887, 12'hff0, 12'h00f, 1, 0, 8'd1};
    tbl[6]  = '{1, 1, 3'd2, 12'h123, 1, 12'h0f0, 12'h887, 12'hff0, 12'h00f, 0, 0, 8'd1};
    tbl[7]  = '{0, 0, 3'd0, 12'h000, 1, 12'h0f0, 12'h887, 12'hff0, 12'h00f, 0, 0, 8'd1};
    tbl[8]  = '{1, 0, 3'd0, 12'h000, 0, 12'h0f0, 12'h111, 12'h123, 12'h00f, 1, 1, 8'd2};
    tbl[9]  = '{1, 0, 3'd0, 12'h000, 0, 12'h0f0, 12'h111, 12'h123, 12'h00f, 1, 0, 8'd2};
    tbl[10] = '{0, 1, 3'd5, 12'h0ab, 0, 12'h0f0, 12'h111, 12'h123, 12'h00f, 1, 0, 8'd2};
    tbl[11] = '{1, 0, 3'd0, 12'h000, 1, 12'h0f0, 12'h111, 12'h123, 12'h00f, 0, 0, 8'd3};
    tbl[12] = '{0, 0, 3'd0, 12'h000, 0, 12'h0f0, 12'h111, 12'h123, 12'h00f, 0, 0, 8'd3};
    tbl[13] = '{1, 0, 3'd0, 12'h000, 0, 12'h0f0, 12'h111, 12'h123, 12'h0ab, 1, 1, 8'd4};
    tbl[14] = '{0, 1, 3'd7, 12'hfff, 0, 12'h0f0, 12'h111, 12'h123, 12'h0ab, 1, 0, 8'd4};

    model_reset();
    do_reset();
    chk("rst_fill", 32'(fill_rgb), 32'h888);
    chk("rst_top", 32'(top_rgb), 32'hff0);
    chk("rst_right", 32'(right_rgb), 32'h00f);
    chk("rst_edge", 32'(edge_en), 32'd1);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_frame", 32'(frame_cnt), 32'd0);
    chk("rst_done", 32'(commit_done), 32'd0);

    for (int i = 0; i < 15; i++) begin
      vblnk = tbl[i].vb; cfg_valid = tbl[i].v; cfg_addr = tbl[i].a;
      cfg_data = tbl[i].d; cfg_commit = tbl[i].c;
      cyc();
      chk($sformatf("vec%0d_fill", i), 32'(fill_rgb), 32'(tbl[i].fill));
      chk($sformatf("vec%0d_alt", i), 32'(alt_rgb), 32'(tbl[i].alt));
      chk($sformatf("vec%0d_top", i), 32'(top_rgb), 32'(tbl[i].top));
      chk($sformatf("vec%0d_right", i), 32'(right_rgb), 32'(tbl[i].right));
      chk($sformatf("vec%0d_ready", i), 32'(cfg_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_done", i), 32'(commit_done), 32'(tbl[i].done));
      chk($sformatf("vec%0d_frame", i), 32'(frame_cnt), 32'(tbl[i].fr));
    end
    idle_in(0);

    // Blink enable: phase toggles every BF frames, then disable clears it immediately.
    write(3'd6, 12'h003, 1'b0);
    write(3'd0, 12'h0f0, 1'b1);
    idle_in(1); cyc();
    chk("blink_on_phase", 32'(blink_phase), 32'd0);
    blink_exp = 3'b000;
    for (int f = 0; f < 5; f++) begin
      frame();
      blink_exp = (f == 0) ? 3'd0 : (f == 1) ? 3'd1 : (f == 2) ? 3'd1 : 3'd0;
      chk($sformatf("blink_f%0d", f), 32'(blink_phase), 32'(blink_exp[0]));
    end
    write(3'd6, 12'h001, 1'b0);
    write(3'd7, 12'hfff, 1'b1);
    idle_in(1); cyc();
    chk("blink_off_phase", 32'(blink_phase), 32'd0);
    chk("blink_off_edge", 32'(edge_en), 32'd1);
    chk("blink_off_done", 32'(commit_done), 32'd1);

    // Reset while a commit is pending discards it.
    write(3'd0, 12'habc, 1'b1);
    rst_n = 0; idle_in(0); cyc();
    rst_n = 1;
    ndone = 0;
    for (int f = 0; f < 3; f++) begin
      idle_in(0); cyc(); if (commit_done) ndone++;
      idle_in(1); cyc(); if (commit_done) ndone++;
    end
    chk("rstpend_done_count", 32'(ndone), 32'd0);
    chk("rstpend_fill", 32'(fill_rgb), 32'h888);
    chk("rstpend_ready", 32'(cfg_ready), 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst_n      = ($urandom_range(299) != 0);
      if ($urandom_range(3) == 0) vblnk = ~vblnk;
      cfg_valid  = $urandom_range(1);
      cfg_addr   = 3'($urandom_range(7));
      cfg_data   = 12'($urandom);
      cfg_commit = ($urandom_range(7) == 0);
      cyc();
    end

    // Frame counter wrap: 2^FW + 1 frames after reset.
    do_reset();
    for (int f = 0; f < (1 << FW) + 1; f++) frame();
    chk("wrap_frame", 32'(frame_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
